// File: rtl/tb_status_monitor_pkg.sv
// Shared types and LED bit map for the cv32e40x tb-wrapper status monitor.
package tb_status_monitor_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4
    } mon_state_e;

    localparam int unsigned LED_PASS    = 0;
    localparam int unsigned LED_FAIL    = 1;
    localparam int unsigned LED_TMO     = 2;
    localparam int unsigned LED_HB      = 3;
    localparam int unsigned LED_NIB_LSB = 4;

    function automatic logic is_terminal(input mon_state_e s);
        return (s == StPass) || (s == StFail) || (s == StTimeout);
    endfunction

endpackage

// File: rtl/tb_status_tick_div.sv
// Free-running power-of-two divider; tick_o is high for the one cycle the count is all-ones.
module tb_status_tick_div #(
    parameter int unsigned HB_DIV_W = 24
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    logic [HB_DIV_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + HB_DIV_W'(1);
        end
    end

    assign tick_o = en_i & (&cnt_q);

endmodule

// File: rtl/tb_status_monitor.sv
// Sticky pass/fail/timeout monitor with heartbeat and scrolling exit-code LEDs.
// Define TB_STATUS_MONITOR_WDT_EN to build the run watchdog (TIMEOUT state).
module tb_status_monitor
    import tb_status_monitor_pkg::*;
#(
    parameter int unsigned LED_W      = 8,
    parameter int unsigned EXIT_W     = 32,
    parameter int unsigned HB_DIV_W   = 24,
    parameter int unsigned WDT_CYCLES = 250000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              tests_passed_i,
    input  logic              tests_failed_i,
    input  logic              exit_valid_i,
    input  logic [EXIT_W-1:0] exit_value_i,
    output logic [LED_W-1:0]  led_o,
    output logic [2:0]        state_o,
    output logic [EXIT_W-1:0] exit_value_o,
    output logic              done_o
);

    localparam int unsigned NIBBLES = EXIT_W / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    mon_state_e        state_q, state_d;
    logic [EXIT_W-1:0] exit_q, exit_d, exit_shift;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              hb_q, hb_d;
    logic              done_q;
    logic [LED_W-1:0]  led_q, led_d, led_hi;
    logic              tick;
    logic              wdt_expire;

    tb_status_tick_div #(
        .HB_DIV_W (HB_DIV_W)
    ) u_tick_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (state_q != StIdle),
        .tick_o (tick)
    );

`ifdef TB_STATUS_MONITOR_WDT_EN
    logic [31:0] wdt_q;

    // Counts cycles spent in RUN; zero on entry so expiry lands WDT_CYCLES after it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_q <= '0;
        end else if (state_q == StRun) begin
            wdt_q <= wdt_q + 32'd1;
        end else begin
            wdt_q <= '0;
        end
    end

    assign wdt_expire = (state_q == StRun) && (wdt_q == 32'(WDT_CYCLES - 1));
`else
    assign wdt_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        exit_d  = exit_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StRun;
            end
            StRun: begin
                if (exit_valid_i) exit_d = exit_value_i;
                if (tests_failed_i) begin
                    state_d = StFail;
                end else if (exit_valid_i) begin
                    state_d = (exit_value_i == '0) ? StPass : StFail;
                end else if (tests_passed_i) begin
                    state_d = StPass;
                end else if (wdt_expire) begin
                    state_d = StTimeout;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        hb_d = hb_q;
        if (is_terminal(state_d)) begin
            hb_d = 1'b1;
        end else if (state_q == StRun && tick) begin
            hb_d = ~hb_q;
        end
    end

    // Scroll only advances once in FAIL, so the display always opens on the LSB nibble.
    always_comb begin
        idx_d = idx_q;
        if (state_q == StFail && tick) begin
            idx_d = (idx_q == IDX_W'(NIBBLES - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign exit_shift = exit_d >> {idx_d, 2'b00};

    if (LED_W > 8) begin : g_led_hi
        logic [LED_W+EXIT_W-1:0] exit_ext;
        assign exit_ext = {{LED_W{1'b0}}, exit_d};
        assign led_hi   = {exit_ext[LED_W-9:0], 8'h00};
    end else begin : g_no_led_hi
        assign led_hi = '0;
    end

    always_comb begin
        led_d           = led_hi;
        led_d[LED_PASS] = (state_d == StPass);
        led_d[LED_FAIL] = (state_d == StFail);
`ifdef TB_STATUS_MONITOR_WDT_EN
        led_d[LED_TMO]  = (state_d == StTimeout);
`else
        led_d[LED_TMO]  = 1'b0;
`endif
        led_d[LED_HB]   = hb_d;
        led_d[LED_NIB_LSB +: 4] = (state_d == StFail && exit_d != '0) ? exit_shift[3:0] : 4'h0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            exit_q  <= '0;
            idx_q   <= '0;
            hb_q    <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            exit_q  <= exit_d;
            idx_q   <= idx_d;
            hb_q    <= hb_d;
            done_q  <= is_terminal(state_d);
            led_q   <= led_d;
        end
    end

    assign state_o      = state_q;
    assign exit_value_o = exit_q;
    assign done_o       = done_q;
    assign led_o        = led_q;

endmodule

// File: tb/tb_tb_status_monitor.sv
// Bench for tb_status_monitor: directed table, hand sequences, and random runs vs a cycle model.
module tb_tb_status_monitor;

    localparam int unsigned LED_W      = 8;
    localparam int unsigned EXIT_W     = 32;
    localparam int unsigned HB_DIV_W   = 3;
    localparam int unsigned WDT_CYCLES = 20;
    localparam int          PERIOD     = 1 << HB_DIV_W;
    localparam int          NIBBLES    = EXIT_W / 4;
`ifdef TB_STATUS_MONITOR_WDT_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic              tests_passed_i = 1'b0;
    logic              tests_failed_i = 1'b0;
    logic              exit_valid_i = 1'b0;
    logic [EXIT_W-1:0] exit_value_i = '0;
    logic [LED_W-1:0]  led_o;
    logic [2:0]        state_o;
    logic [EXIT_W-1:0] exit_value_o;
    logic              done_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state number, captured code, cycles since leaving IDLE,
    // cycles in RUN, heartbeat level and scroll position.
    int          m_state;
    logic [31:0] m_exit;
    int          m_active;
    int          m_run;
    bit          m_hb;
    int          m_idx;

    tb_status_monitor #(
        .LED_W      (LED_W),
        .EXIT_W     (EXIT_W),
        .HB_DIV_W   (HB_DIV_W),
        .WDT_CYCLES (WDT_CYCLES)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .tests_passed_i (tests_passed_i),
        .tests_failed_i (tests_failed_i),
        .exit_valid_i   (exit_valid_i),
        .exit_value_i   (exit_value_i),
        .led_o          (led_o),
        .state_o        (state_o),
        .exit_value_o   (exit_value_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_led();
        logic [3:0] nib;
        nib = 4'h0;
        if (m_state == 3 && m_exit != 0) nib = 4'((m_exit >> (4 * m_idx)) & 32'hF);
        return {nib, m_hb, m_state == 4, m_state == 3, m_state == 2};
    endfunction

    task automatic model_reset();
        m_state = 0; m_exit = '0; m_active = 0; m_run = 0; m_hb = 1'b0; m_idx = 0;
    endtask

    task automatic model_step();
        bit          tick;
        int          ns;
        logic [31:0] nx;
        tick = (m_state != 0) && (m_active % PERIOD == PERIOD - 1);
        ns = m_state;
        nx = m_exit;
        if (m_state == 0) begin
            if (start_i) ns = 1;
        end else if (m_state == 1) begin
            if (exit_valid_i) nx = exit_value_i;
            if (tests_failed_i) ns = 3;
            else if (exit_valid_i) ns = (exit_value_i == 0) ? 2 : 3;
            else if (tests_passed_i) ns = 2;
            else if (WDT_EN && m_run == WDT_CYCLES - 1) ns = 4;
        end
        if (ns >= 2) m_hb = 1'b1;
        else if (m_state == 1 && tick) m_hb = !m_hb;
        if (m_state == 3 && tick) m_idx = (m_idx + 1) % NIBBLES;
        m_active = (m_state != 0) ? m_active + 1 : 0;
        m_run    = (m_state == 1) ? m_run + 1 : 0;
        m_state  = ns;
        m_exit   = nx;
    endtask

    task automatic check_model(input string name);
        check(name, {state_o, done_o, exit_value_o, led_o},
              {3'(m_state), m_state >= 2, m_exit, model_led()});
    endtask

    task automatic cycle(input bit st, input bit ps, input bit fl, input bit ev,
                         input logic [31:0] val);
        start_i = st; tests_passed_i = ps; tests_failed_i = fl;
        exit_valid_i = ev; exit_value_i = val;
        @(posedge clk_i);
        model_step();
        #1;
        check_model("model");
    endtask

    // Reset is checked before any clock edge to prove it is asynchronous.
    task automatic do_reset();
        rst_ni = 1'b0;
        start_i = 0; tests_passed_i = 0; tests_failed_i = 0; exit_valid_i = 0; exit_value_i = '0;
        model_reset();
        #1;
        check("reset_zero", {state_o, done_o, exit_value_o, led_o}, 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    typedef struct {
        int          pre;
        bit          ps;
        bit          fl;
        bit          ev;
        logic [31:0] val;
        int          exp_state;
        logic [31:0] exp_exit;
        logic [3:0]  exp_led;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{5, 1'b1, 1'b0, 1'b0, 32'h0,    2, 32'h0,    4'b1001};
        vecs[1] = '{3, 1'b0, 1'b1, 1'b0, 32'h0,    3, 32'h0,    4'b1010};
        vecs[2] = '{2, 1'b0, 1'b0, 1'b1, 32'h0,    2, 32'h0,    4'b1001};
        vecs[3] = '{4, 1'b0, 1'b0, 1'b1, 32'hA5,   3, 32'hA5,   4'b1010};
        vecs[4] = '{1, 1'b1, 1'b1, 1'b0, 32'h0,    3, 32'h0,    4'b1010};
        vecs[5] = '{6, 1'b0, 1'b1, 1'b1, 32'h7,    3, 32'h7,    4'b1010};
        vecs[6] = '{0, 1'b1, 1'b0, 1'b1, 32'h3,    3, 32'h3,    4'b1010};

        model_reset();
        for (int i = 0; i < 7; i++) begin
            do_reset();
            cycle(1, 0, 0, 0, 0);
            repeat (vecs[i].pre) cycle(1, 0, 0, 0, 0);
            cycle(1, vecs[i].ps, vecs[i].fl, vecs[i].ev, vecs[i].val);
            check("vec_state", 64'(state_o), 64'(vecs[i].exp_state));
            check("vec_exit", 64'(exit_value_o), 64'(vecs[i].exp_exit));
            check("vec_done", 64'(done_o), 64'd1);
            check("vec_led", 64'(led_o[3:0]), 64'(vecs[i].exp_led));
            cycle(0, 1, 1, 1, 32'h1234);
            cycle(0, 0, 0, 0, 0);
            check("vec_sticky", 64'(state_o), 64'(vecs[i].exp_state));
            check("vec_sticky_exit", 64'(exit_value_o), 64'(vecs[i].exp_exit));
        end

        // Nibble scroll: enter FAIL right after a divider wrap.
        do_reset();
        cycle(1, 0, 0, 0, 0);
        repeat (7) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 32'hA5);
        check("nib_first", 64'(led_o[7:4]), 64'h5);
        repeat (8) cycle(0, 0, 0, 0, 0);
        check("nib_second", 64'(led_o[7:4]), 64'hA);
        repeat (8) cycle(0, 0, 0, 0, 0);
        check("nib_third", 64'(led_o[7:4]), 64'h0);
        repeat (40) cycle(0, 0, 0, 0, 0);
        check("nib_last", 64'(led_o[7:4]), 64'h0);
        repeat (8) cycle(0, 0, 0, 0, 0);
        check("nib_wrap", 64'(led_o[7:4]), 64'h5);

        // Heartbeat in RUN, then an asynchronous reset mid-run.
        do_reset();
        cycle(1, 0, 0, 0, 0);
        repeat (7) cycle(1, 0, 0, 0, 0);
        check("hb_low", 64'(led_o[3]), 64'd0);
        cycle(1, 0, 0, 0, 0);
        check("hb_rise", 64'(led_o[3]), 64'd1);
        repeat (7) cycle(1, 0, 0, 0, 0);
        check("hb_hold", 64'(led_o[3]), 64'd1);
        cycle(1, 0, 0, 0, 0);
        check("hb_fall", 64'(led_o[3]), 64'd0);
        check("hb_run", 64'(state_o), 64'd1);
        #2;
        do_reset();

        // IDLE ignores events and keeps the divider frozen.
        repeat (5) cycle(0, 1, 1, 1, 32'h5);
        check("idle_state", 64'(state_o), 64'd0);
        check("idle_led", 64'(led_o), 64'd0);
        check("idle_exit", 64'(exit_value_o), 64'd0);
        cycle(1, 0, 0, 0, 0);
        repeat (7) cycle(1, 0, 0, 0, 0);
        check("idle_div_low", 64'(led_o[3]), 64'd0);
        cycle(1, 0, 0, 0, 0);
        check("idle_div_rise", 64'(led_o[3]), 64'd1);

        // Watchdog expiry and an event on the expiry cycle.
        do_reset();
        cycle(1, 0, 0, 0, 0);
        repeat (19) cycle(1, 0, 0, 0, 0);
        check("wdt_before", 64'(state_o), 64'd1);
        cycle(1, 0, 0, 0, 0);
        check("wdt_state", 64'(state_o), WDT_EN ? 64'd4 : 64'd1);
        check("wdt_led", 64'(led_o[2]), WDT_EN ? 64'd1 : 64'd0);
        check("wdt_done", 64'(done_o), WDT_EN ? 64'd1 : 64'd0);
        do_reset();
        cycle(1, 0, 0, 0, 0);
        repeat (19) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("wdt_event_wins", 64'(state_o), 64'd2);

        // Random runs against the model.
        for (int r = 0; r < 25; r++) begin
            bit quiet;
            quiet = (r % 4 == 0);
            do_reset();
            for (int c = 0; c < 60; c++) begin
                logic [31:0] v;
                v = ($urandom % 3 == 0) ? 32'h0 : $urandom;
                cycle(($urandom % 4) != 0,
                      !quiet && ($urandom % 16 == 0),
                      !quiet && ($urandom % 20 == 0),
                      !quiet && ($urandom % 12 == 0),
                      v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
